inference_ctrl: RTL

INFERENCE_CTRL -- requirements
Module: inference_ctrl

---
 rtl/inference_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inference_ctrl.sv
// -----------------------------------------------------------------------------
// inference_ctrl
//
// Sequences one image through the CNN datapath:
//   IDLE -> FLUSH (pipe_rst_n low) -> STREAM (read memory, forward pixels)
//        -> DRAIN (wait for the decision stage) -> DONE (one-cycle pulse) -> IDLE
//
// Ports
//   clk, rst_n         clock (rising edge) and synchronous active-low reset
//   start              one-cycle request, accepted only in IDLE with abort low
//   abort              returns any busy state to IDLE on the next cycle
//   mem_addr/mem_rd_en image-memory read port; mem_rdata arrives one cycle later
//   mem_rdata          pixel returned by the image memory
//   pix_out/pix_valid  pixel stream to the first convolution stage
//   pipe_rst_n         synchronous active-low reset to the downstream chain
//   result_valid/result decision-stage output, observed only in DRAIN
//   busy, done         status; done is a one-cycle completion pulse
//   decision_out       captured class (4'hF on timeout), held until next done
//   timeout            set with done when no result arrived
//   img_count          successful inferences, modulo 256
//   state_dbg          current FSM state, for observation only
//
// Handshake: start, abort and result_valid are single-cycle level samples taken
// on the rising edge; there is no backpressure. pix_valid qualifies pix_out on
// every cycle it is high, and pix_out is forced to zero when pix_valid is low.
// -----------------------------------------------------------------------------
module inference_ctrl #(
  parameter int IMG_PIXELS     = 784,
  parameter int ADDR_BITS      = 10,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           pix_out,
  output logic                 pix_valid,
  output logic                 pipe_rst_n,
  input  logic                 result_valid,
  input  logic [3:0]           result,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           decision_out,
  output logic                 timeout,
  output logic [7:0]           img_count,
  output logic [2:0]           state_dbg
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [FW-1:0]   flush_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            capture;
  logic            expire;
  logic            abort_busy;

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    expire     = 1'b0;
    abort_busy = abort && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start && !abort) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state_next = S_STREAM;
      end
      S_STREAM: begin
        if (mem_addr == ADDR_BITS'(IMG_PIXELS - 1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // A result on the final counted cycle still wins over the timeout.
        if (result_valid) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (drain_cnt == DW'(TIMEOUT_CYCLES - 1)) begin
          expire     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort_busy) begin
      state_next = S_IDLE;
      capture    = 1'b0;
      expire     = 1'b0;
    end
  end

  assign mem_rd_en = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;
  assign pix_out   = pix_valid ? mem_rdata : 8'd0;

  // ---------------------------------------------------------------------------
  // State, counters and held outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      drain_cnt    <= '0;
      mem_addr     <= '0;
      pix_valid    <= 1'b0;
      pipe_rst_n   <= 1'b0;
      decision_out <= 4'd0;
      timeout      <= 1'b0;
      img_count    <= 8'd0;
    end else begin
      state <= state_next;

      // Counters run only while the state persists, so each starts at 0 on entry.
      flush_cnt <= ((state == S_FLUSH) && (state_next == S_FLUSH)) ? flush_cnt + 1'b1 : '0;
      drain_cnt <= ((state == S_DRAIN) && (state_next == S_DRAIN)) ? drain_cnt + 1'b1 : '0;
      mem_addr  <= ((state == S_STREAM) && (state_next == S_STREAM)) ? mem_addr + 1'b1 : '0;

      // Memory data lags the read strobe by one cycle; abort kills the
      // in-flight pixel so pix_valid drops together with mem_rd_en.
      pix_valid <= mem_rd_en && !abort;

      // Chain held in reset through FLUSH, and for one cycle after an abort.
      pipe_rst_n <= !(abort_busy || (state_next == S_FLUSH));

      if (capture) begin
        decision_out <= result;
        timeout      <= 1'b0;
        img_count    <= img_count + 8'd1;
      end else if (expire) begin
        decision_out <= 4'hF;
        timeout      <= 1'b1;
      end
    end
  end

endmodule
